// File: rtl/fft16_col_transpose_pkg.sv
// Shared FFT16 transpose definitions: lane count and the Gray row order used by the twiddle ROM.
package fft16_col_transpose_pkg;

  localparam int NUM_LANES = 4;
  localparam int ROW_W     = 2;

  // Row index for the k-th captured row of a frame: 0,1,3,2 (binary-reflected Gray).
  function automatic logic [ROW_W-1:0] gray_row(input logic [ROW_W-1:0] cnt);
    return {cnt[1], cnt[1] ^ cnt[0]};
  endfunction

endpackage

// File: rtl/fft16_transpose_bank.sv
// One 4x4 complex sample bank: whole-row write port, whole-column combinational read port.
module fft16_transpose_bank
  import fft16_col_transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 wr_en,
  input  logic [ROW_W-1:0]                     wr_row,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wr_x,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wr_y,
  input  logic [ROW_W-1:0]                     rd_col,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rd_x,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rd_y
);

  // mem_q[r][j] = lane j of row r; contents are deliberately not reset
  logic [NUM_LANES-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0] mx_q, mx_d, my_q, my_d;

  // Next-state: overwrite one full row when enabled
  always_comb begin
    mx_d = mx_q;
    my_d = my_q;
    if (wr_en) begin
      mx_d[wr_row] = wr_x;
      my_d[wr_row] = wr_y;
    end
  end

  // Bank storage
  always_ff @(posedge clk) begin
    mx_q <= mx_d;
    my_q <= my_d;
  end

  // Column read: output lane r carries element [r][col]
  always_comb begin
    rd_x = '0;
    rd_y = '0;
    for (int r = 0; r < NUM_LANES; r++) begin
      rd_x[r] = mx_q[r][rd_col];
      rd_y[r] = my_q[r][rd_col];
    end
  end

endmodule

// File: rtl/fft16_col_transpose.sv
// Ping-pong 4x4 corner turn: captures Gray-ordered rows, emits natural-order columns 4 cycles later.
module fft16_col_transpose
  import fft16_col_transpose_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_in,
  input  logic [DATA_WIDTH-1:0] x_a_in,
  input  logic [DATA_WIDTH-1:0] y_a_in,
  input  logic [DATA_WIDTH-1:0] x_b_in,
  input  logic [DATA_WIDTH-1:0] y_b_in,
  input  logic [DATA_WIDTH-1:0] x_c_in,
  input  logic [DATA_WIDTH-1:0] y_c_in,
  input  logic [DATA_WIDTH-1:0] x_d_in,
  input  logic [DATA_WIDTH-1:0] y_d_in,
  output logic                  ctrl_out,
  output logic [DATA_WIDTH-1:0] xx_a_out,
  output logic [DATA_WIDTH-1:0] yy_a_out,
  output logic [DATA_WIDTH-1:0] xx_b_out,
  output logic [DATA_WIDTH-1:0] yy_b_out,
  output logic [DATA_WIDTH-1:0] xx_c_out,
  output logic [DATA_WIDTH-1:0] yy_c_out,
  output logic [DATA_WIDTH-1:0] xx_d_out,
  output logic [DATA_WIDTH-1:0] yy_d_out
);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] in_x, in_y;
  assign in_x = {x_d_in, x_c_in, x_b_in, x_a_in};
  assign in_y = {y_d_in, y_c_in, y_b_in, y_a_in};

  logic [ROW_W-1:0] wr_cnt_q, wr_cnt_d, rd_col_q, rd_col_d;
  logic             wr_active_q, wr_active_d, wr_bank_q, wr_bank_d;
  logic             rd_active_q, rd_active_d, rd_bank_q, rd_bank_d;
  logic             ctrl_out_q, ctrl_out_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;

  logic             wr_we, arm;
  logic [ROW_W-1:0] wr_row;
  logic [1:0][NUM_LANES-1:0][DATA_WIDTH-1:0] bank_rx, bank_ry;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft16_transpose_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk    (clk),
      .wr_en  (wr_we && (wr_bank_q == 1'(b))),
      .wr_row (wr_row),
      .wr_x   (in_x),
      .wr_y   (in_y),
      .rd_col (rd_col_q),
      .rd_x   (bank_rx[b]),
      .rd_y   (bank_ry[b])
    );
  end

  // Write side: ctrl_in always (re)starts row 0 in the current bank; 4th row completes and flips banks
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_active_d = wr_active_q;
    wr_bank_d   = wr_bank_q;
    wr_we       = 1'b0;
    wr_row      = '0;
    arm         = 1'b0;
    if (ctrl_in) begin
      wr_we       = 1'b1;
      wr_cnt_d    = 2'd1;
      wr_active_d = 1'b1;
    end else if (wr_active_q) begin
      wr_we  = 1'b1;
      wr_row = gray_row(wr_cnt_q);
      if (wr_cnt_q == 2'd3) begin
        wr_cnt_d    = '0;
        wr_active_d = 1'b0;
        wr_bank_d   = ~wr_bank_q;
        arm         = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 2'd1;
      end
    end
  end

  // Read side: sweep columns 0..3 of the completed bank, loading the output registers
  always_comb begin
    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    rd_col_d    = rd_col_q;
    ctrl_out_d  = 1'b0;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    if (rd_active_q) begin
      out_x_d    = bank_rx[rd_bank_q];
      out_y_d    = bank_ry[rd_bank_q];
      ctrl_out_d = (rd_col_q == 2'd0);
      rd_col_d   = rd_col_q + 2'd1;
      if (rd_col_q == 2'd3) rd_active_d = 1'b0;
    end
    // a freshly completed frame takes over exactly when the previous sweep ends
    if (arm) begin
      rd_active_d = 1'b1;
      rd_bank_d   = wr_bank_q;
      rd_col_d    = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_active_q <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_col_q    <= '0;
      ctrl_out_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_active_q <= wr_active_d;
      wr_bank_q   <= wr_bank_d;
      rd_active_q <= rd_active_d;
      rd_bank_q   <= rd_bank_d;
      rd_col_q    <= rd_col_d;
      ctrl_out_q  <= ctrl_out_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign ctrl_out = ctrl_out_q;
  assign {xx_d_out, xx_c_out, xx_b_out, xx_a_out} = out_x_q;
  assign {yy_d_out, yy_c_out, yy_b_out, yy_a_out} = out_y_q;

endmodule

// File: tb/tb_fft16_col_transpose.sv
// Directed bench for fft16_col_transpose with a frame-timeline reference model.
module tb_fft16_col_transpose;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_in = 1'b0;
  logic [7:0] in_x [4];
  logic [7:0] in_y [4];
  logic ctrl_out;
  logic [7:0] xx_a, yy_a, xx_b, yy_b, xx_c, yy_c, xx_d, yy_d;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  fft16_col_transpose #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in),
    .x_a_in(in_x[0]), .y_a_in(in_y[0]), .x_b_in(in_x[1]), .y_b_in(in_y[1]),
    .x_c_in(in_x[2]), .y_c_in(in_y[2]), .x_d_in(in_x[3]), .y_d_in(in_y[3]),
    .ctrl_out(ctrl_out),
    .xx_a_out(xx_a), .yy_a_out(yy_a), .xx_b_out(xx_b), .yy_b_out(yy_b),
    .xx_c_out(xx_c), .yy_c_out(yy_c), .xx_d_out(xx_d), .yy_d_out(yy_d)
  );

  // ---------------- reference model: rows collected per frame, columns scheduled on a timeline
  int         seq [4] = '{0, 1, 3, 2};
  logic [7:0] mx [4][4];
  logic [7:0] my [4][4];
  bit         sv [1024];
  bit         sc [1024];
  logic [7:0] sxx [1024][4];
  logic [7:0] syy [1024][4];
  logic [7:0] ex [4];
  logic [7:0] ey [4];
  bit         ectrl = 1'b0;
  bit         mdl_valid = 1'b0;

  initial begin
    int e;
    int got;
    e = 0;
    got = 0;
    forever begin
      @(posedge clk);
      e++;
      if (rst) begin
        got = 0;
        for (int k = e; k < e + 8 && k < 1024; k++) sv[k] = 1'b0;
        for (int j = 0; j < 4; j++) begin ex[j] = 8'h00; ey[j] = 8'h00; end
        ectrl = 1'b0;
      end else begin
        if (e < 1024 && sv[e]) begin
          for (int j = 0; j < 4; j++) begin ex[j] = sxx[e][j]; ey[j] = syy[e][j]; end
          ectrl = sc[e];
        end else begin
          ectrl = 1'b0;
        end
        if (ctrl_in) got = 0;
        if (ctrl_in || got > 0) begin
          for (int j = 0; j < 4; j++) begin
            mx[seq[got]][j] = in_x[j];
            my[seq[got]][j] = in_y[j];
          end
          got++;
          if (got == 4) begin
            got = 0;
            for (int c = 0; c < 4; c++) begin
              if (e + 1 + c < 1024) begin
                sv[e+1+c] = 1'b1;
                sc[e+1+c] = (c == 0);
                for (int j = 0; j < 4; j++) begin
                  sxx[e+1+c][j] = mx[j][c];
                  syy[e+1+c][j] = my[j][c];
                end
              end
            end
          end
        end
      end
      mdl_valid = 1'b1;
    end
  end

  // Every-cycle compare against the model, away from the active edge
  initial begin
    logic [64:0] got_v, exp_v;
    forever begin
      @(negedge clk);
      if (mdl_valid) begin
        got_v = {ctrl_out, xx_d, xx_c, xx_b, xx_a, yy_d, yy_c, yy_b, yy_a};
        exp_v = {ectrl, ex[3], ex[2], ex[1], ex[0], ey[3], ey[2], ey[1], ey[0]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, got_v, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ctrl_out === 1'b1) pulses++;
  endtask

  task automatic row(input bit c, input logic [7:0] base, input int r);
    for (int j = 0; j < 4; j++) begin
      in_x[j] = base + 8'(r * 16) + 8'(j);
      in_y[j] = ~in_x[j];
    end
    ctrl_in = c;
    tick();
  endtask

  task automatic rowv(input bit c, input logic [7:0] v);
    for (int j = 0; j < 4; j++) begin in_x[j] = v; in_y[j] = ~v; end
    ctrl_in = c;
    tick();
  endtask

  task automatic frame(input logic [7:0] base);
    row(1'b1, base, 0);
    row(1'b0, base, 1);
    row(1'b0, base, 3);
    row(1'b0, base, 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        in_x[j] = 8'($urandom);
        in_y[j] = 8'($urandom);
      end
      ctrl_in = 1'b0;
      tick();
    end
  endtask

  function automatic logic [63:0] outs();
    return {xx_d, xx_c, xx_b, xx_a, yy_d, yy_c, yy_b, yy_a};
  endfunction

  // ---------------- directed sequence
  initial begin
    int p0;
    logic [31:0] ex_col;
    for (int j = 0; j < 4; j++) begin in_x[j] = 8'h00; in_y[j] = 8'h00; end
    @(negedge clk);
    // reset with random inputs and random ctrl_in
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) begin in_x[j] = 8'($urandom); in_y[j] = 8'($urandom); end
      ctrl_in = 1'($urandom);
      tick();
    end
    chk("reset_outs", outs(), 64'h0);
    chk("reset_ctrl", {63'h0, ctrl_out}, 64'h0);
    rst = 1'b0;
    idle(3);
    chk("no_spurious_pulse", 64'(pulses), 64'd0);

    // single frame, x = {row,lane}, y = ~x
    frame(8'h00);
    for (int c = 0; c < 4; c++) begin
      idle(1);
      ex_col = {8'(8'h30 + c), 8'(8'h20 + c), 8'(8'h10 + c), 8'(8'h00 + c)};
      chk("single_ctrl", {63'h0, ctrl_out}, {63'h0, (c == 0)});
      chk("single_x", {32'h0, xx_d, xx_c, xx_b, xx_a}, {32'h0, ex_col});
      chk("single_y", {32'h0, yy_d, yy_c, yy_b, yy_a}, {32'h0, ~ex_col});
    end
    idle(2);
    chk("idle_hold_x", {32'h0, xx_d, xx_c, xx_b, xx_a}, 64'h0000_0000_3323_1303);

    // three back-to-back frames
    p0 = pulses;
    frame(8'h40);
    frame(8'h80);
    frame(8'hC0);
    idle(5);
    chk("b2b_pulses", 64'(pulses - p0), 64'd3);

    // abort: ctrl_in at t0 and t0+2, then four good rows
    p0 = pulses;
    row(1'b1, 8'h40, 0);
    row(1'b0, 8'h40, 1);
    frame(8'h80);
    idle(1);
    chk("abort_ctrl", {63'h0, ctrl_out}, 64'h1);
    chk("abort_col0_x", {32'h0, xx_d, xx_c, xx_b, xx_a}, 64'h0000_0000_b0a0_9080);
    idle(5);
    chk("abort_pulses", 64'(pulses - p0), 64'd1);

    // retrigger on the completion edge discards the previous frame
    p0 = pulses;
    row(1'b1, 8'h20, 0);
    row(1'b0, 8'h20, 1);
    row(1'b0, 8'h20, 3);
    frame(8'h60);
    idle(6);
    chk("complete_abort_pulses", 64'(pulses - p0), 64'd1);

    // reset while column 1 is on the outputs
    p0 = pulses;
    frame(8'h00);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midread_rst_outs", outs(), 64'h0);
    idle(6);
    chk("midread_rst_pulses", 64'(pulses - p0), 64'd1);
    chk("midread_rst_hold", outs(), 64'h0);

    // extreme values alternating by row: rows 0,1,3,2 -> 80,7F,7F,80
    rowv(1'b1, 8'h80);
    rowv(1'b0, 8'h7F);
    rowv(1'b0, 8'h7F);
    rowv(1'b0, 8'h80);
    idle(1);
    chk("extreme_x", {32'h0, xx_d, xx_c, xx_b, xx_a}, 64'h0000_0000_7f80_7f80);
    chk("extreme_y", {32'h0, yy_d, yy_c, yy_b, yy_a}, 64'h0000_0000_807f_807f);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
